// File: rtl/fft_sched_pkg.sv
// Shared types and helpers for the FFT frame scheduler.
package fft_sched_pkg;

    localparam int unsigned DEFAULT_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ARM   = 3'd2,
        START = 3'd3,
        RUN   = 3'd4,
        DONE  = 3'd5
    } sched_state_e;

    // Reverse the low `size` bits of value; upper result bits are zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int unsigned size);
        logic [31:0] rev;
        rev = '0;
        for (int j = 0; j < 32; j++) begin
            rev[31-j] = value[j];
        end
        return rev >> (32 - size);
    endfunction

endpackage

// File: rtl/fft_frame_scheduler_watchdog.sv
// Per-stage watchdog: counts idle cycles, flags when the terminal count TIMEOUT-1 is held.
module fft_stage_watchdog
    import fft_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned TO_W    = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam logic [TO_W-1:0] TERM = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (clear) begin
            wd_cnt <= '0;
        end else if (enable) begin
            wd_cnt <= wd_cnt + TO_W'(1);
        end
    end

    assign expire_c = (wd_cnt == TERM);

endmodule

// File: rtl/fft_frame_scheduler.sv
// Frame sequencer: loads N samples at bit-reversed addresses, starts stage 0,
// then follows per-stage completion pulses to frame_done, aborting on error.
module fft_frame_scheduler
    import fft_sched_pkg::*;
#(
    parameter int unsigned bit_width = 24,
    parameter int unsigned N         = 16,
    parameter int unsigned SIZE      = 4,
    parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int unsigned TO_W      = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [bit_width-1:0] s_re,
    input  logic [bit_width-1:0] s_im,
    output logic                 load_data,
    output logic [SIZE-1:0]      invert_addr,
    output logic [bit_width-1:0] re_load,
    output logic [bit_width-1:0] im_load,
    output logic                 start_flag,
    input  logic [SIZE-1:0]      stage_done,
    output logic [SIZE-1:0]      cur_stage,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err
);

    sched_state_e state, state_d;

    logic [SIZE-1:0]      load_cnt, load_cnt_d;
    logic [SIZE-1:0]      cur_stage_d;
    logic [SIZE-1:0]      invert_addr_d;
    logic [bit_width-1:0] re_d, im_d;
    logic                 load_data_d, start_flag_d, frame_done_d, err_d;
    logic                 accept_c, wd_clr_c, wd_en_c, wd_expire_c;

    assign s_ready  = (state == IDLE) || (state == LOAD);
    assign accept_c = s_valid && s_ready;

    fft_stage_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (wd_clr_c),
        .enable   (wd_en_c),
        .expire_c (wd_expire_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            load_cnt    <= '0;
            cur_stage   <= '0;
            load_data   <= 1'b0;
            invert_addr <= '0;
            re_load     <= '0;
            im_load     <= '0;
            start_flag  <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            load_cnt    <= load_cnt_d;
            cur_stage   <= cur_stage_d;
            load_data   <= load_data_d;
            invert_addr <= invert_addr_d;
            re_load     <= re_d;
            im_load     <= im_d;
            start_flag  <= start_flag_d;
            frame_done  <= frame_done_d;
            err         <= err_d;
            busy        <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d       = state;
        load_cnt_d    = load_cnt;
        cur_stage_d   = cur_stage;
        load_data_d   = 1'b0;
        invert_addr_d = invert_addr;
        re_d          = re_load;
        im_d          = im_load;
        start_flag_d  = 1'b0;
        frame_done_d  = 1'b0;
        err_d         = 1'b0;
        wd_clr_c      = 1'b0;
        wd_en_c       = 1'b0;

        // Sample write path: one-cycle registered RAM write at the bit-reversed index
        if (accept_c) begin
            load_data_d   = 1'b1;
            invert_addr_d = SIZE'(bit_reverse(32'(load_cnt), SIZE));
            re_d          = s_re;
            im_d          = s_im;
            load_cnt_d    = load_cnt + SIZE'(1);
        end

        case (state)
            IDLE: begin
                if (accept_c) state_d = LOAD;
            end
            LOAD: begin
                if (accept_c && (load_cnt == SIZE'(N - 1))) begin
                    state_d    = ARM;
                    load_cnt_d = '0;
                end
            end
            ARM: begin
                // Extra cycle lets the final RAM write land before the start pulse
                state_d      = START;
                start_flag_d = 1'b1;
            end
            START: begin
                state_d     = RUN;
                cur_stage_d = '0;
                wd_clr_c    = 1'b1;
            end
            RUN: begin
                if (stage_done == '0) begin
                    if (wd_expire_c) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wd_en_c = 1'b1;
                    end
                end else if (stage_done == (SIZE'(1) << cur_stage)) begin
                    cur_stage_d = cur_stage + SIZE'(1);
                    wd_clr_c    = 1'b1;
                    if (cur_stage == SIZE'(SIZE - 1)) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Scoreboard bench for fft_frame_scheduler: load path, stage tracking, errors, reset.
module tb_fft_frame_scheduler;

    localparam int unsigned BW   = 24;
    localparam int unsigned NPTS = 16;
    localparam int unsigned SZ   = 4;
    localparam int unsigned TMO  = 8;
    localparam int unsigned TOW  = 11;

    typedef struct {
        int            idx;
        logic [SZ-1:0] addr;
        logic [BW-1:0] re;
        logic [BW-1:0] im;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [BW-1:0] s_re = '0;
    logic [BW-1:0] s_im = '0;
    logic          load_data;
    logic [SZ-1:0] invert_addr;
    logic [BW-1:0] re_load;
    logic [BW-1:0] im_load;
    logic          start_flag;
    logic [SZ-1:0] stage_done = '0;
    logic [SZ-1:0] cur_stage;
    logic          busy;
    logic          frame_done;
    logic          err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   exp_start = -1;
    int   loads    = 0;
    int   starts   = 0;
    int   loads0   = 0;
    int   starts0  = 0;
    bit   mon_en   = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    fft_frame_scheduler #(
        .bit_width (BW),
        .N         (NPTS),
        .SIZE      (SZ),
        .TIMEOUT   (TMO),
        .TO_W      (TOW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_re        (s_re),
        .s_im        (s_im),
        .load_data   (load_data),
        .invert_addr (invert_addr),
        .re_load     (re_load),
        .im_load     (im_load),
        .start_flag  (start_flag),
        .stage_done  (stage_done),
        .cur_stage   (cur_stage),
        .busy        (busy),
        .frame_done  (frame_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int brev(input int v);
        int r;
        r = 0;
        for (int j = 0; j < int'(SZ); j++) begin
            if (((v >> j) & 1) != 0) r = r | (1 << (int'(SZ) - 1 - j));
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on every RAM write, times the start pulse
    always @(negedge clk) begin
        if (mon_en) begin
            if (load_data === 1'b1) begin
                loads++;
                if (sb.size() == 0) begin
                    check("load_spurious", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("addr", 64'(invert_addr), 64'(mon_e.addr));
                    check("re",   64'(re_load),     64'(mon_e.re));
                    check("im",   64'(im_load),     64'(mon_e.im));
                    if (mon_e.idx == 1) check("addr_i1", 64'(invert_addr), 64'd8);
                    if (mon_e.idx == 3) check("addr_i3", 64'(invert_addr), 64'd12);
                    if (mon_e.idx == 5) check("addr_i5", 64'(invert_addr), 64'd10);
                end
            end
            if (start_flag === 1'b1) begin
                starts++;
                check("start_cycle", 64'(cyc), 64'(exp_start));
            end
        end
    end

    task automatic send_frame(input int gap);
        exp_t e;
        for (int i = 0; i < int'(NPTS); i++) begin
            s_valid = 1'b1;
            s_re    = BW'(i);
            s_im    = BW'(-i);
            e.idx   = i;
            e.addr  = SZ'(brev(i));
            e.re    = BW'(i);
            e.im    = BW'(-i);
            sb.push_back(e);
            tick();
            if (i == int'(NPTS) - 1) exp_start = cyc + 1;
            s_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                s_re = BW'($urandom);
                s_im = BW'($urandom);
                tick();
            end
        end
    endtask

    task automatic wait_start();
        int k;
        k = 0;
        while (start_flag !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        check("start_seen", 64'(start_flag), 64'd1);
    endtask

    // Load one frame and leave the bench in the START cycle
    task automatic frame(input int gap);
        loads0  = loads;
        starts0 = starts;
        send_frame(gap);
        check("ready_after_load", 64'(s_ready), 64'd0);
        wait_start();
        check("load_pulses", 64'(loads - loads0), 64'(NPTS));
        check("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_stages();
        stage_done = '0;
        for (int s = 0; s < int'(SZ); s++) begin
            repeat (5) tick();
            check("stage_pre", 64'(cur_stage), 64'(s));
            stage_done = SZ'(1 << s);
            tick();
            stage_done = '0;
            check("stage_err", 64'(err), 64'd0);
            if (s < int'(SZ) - 1) begin
                check("stage_post", 64'(cur_stage), 64'(s + 1));
                check("no_early_done", 64'(frame_done), 64'd0);
            end else begin
                check("frame_done", 64'(frame_done), 64'd1);
                check("busy_in_done", 64'(busy), 64'd1);
            end
        end
        tick();
        check("frame_done_low", 64'(frame_done), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        check("ready_after", 64'(s_ready), 64'd1);
        check("one_start", 64'(starts - starts0), 64'd1);
    endtask

    initial begin
        // Reset with s_valid held high
        rst = 1'b1;
        s_valid = 1'b1;
        repeat (3) tick();
        check("rst_ready", 64'(s_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_load", 64'(load_data), 64'd0);
        check("rst_start", 64'(start_flag), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_stage", 64'(cur_stage), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        s_valid = 1'b0;
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Contiguous frame through all stages
        frame(0);
        run_stages();

        // Wrong stage after advancing to stage 1
        frame(0);
        tick();
        check("ooo_stage0", 64'(cur_stage), 64'd0);
        stage_done = 4'b0001;
        tick();
        stage_done = '0;
        check("ooo_stage1", 64'(cur_stage), 64'd1);
        stage_done = 4'b0100;
        tick();
        stage_done = '0;
        check("ooo_err", 64'(err), 64'd1);
        check("ooo_busy", 64'(busy), 64'd0);
        check("ooo_no_done", 64'(frame_done), 64'd0);
        tick();
        check("ooo_err_clr", 64'(err), 64'd0);
        check("ooo_ready", 64'(s_ready), 64'd1);
        check("ooo_start", 64'(starts - starts0), 64'd1);

        // Multiple bits set at stage 0
        frame(0);
        tick();
        stage_done = 4'b0011;
        tick();
        stage_done = '0;
        check("multi_err", 64'(err), 64'd1);
        check("multi_busy", 64'(busy), 64'd0);
        tick();
        check("multi_err_clr", 64'(err), 64'd0);

        // Watchdog: no stage events at all
        frame(0);
        for (int k = 1; k <= int'(TMO); k++) begin
            tick();
            check("to_wait_err", 64'(err), 64'd0);
            check("to_wait_busy", 64'(busy), 64'd1);
        end
        tick();
        check("to_err", 64'(err), 64'd1);
        check("to_busy", 64'(busy), 64'd0);
        tick();
        check("to_err_clr", 64'(err), 64'd0);
        check("to_idle", 64'(busy), 64'd0);

        // Throttled load, then reset while tracking stage 2
        frame(1);
        tick();
        stage_done = 4'b0001;
        tick();
        stage_done = 4'b0010;
        tick();
        stage_done = '0;
        check("mid_stage2", 64'(cur_stage), 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_stage", 64'(cur_stage), 64'd0);
        check("mid_rst_ready", 64'(s_ready), 64'd1);
        check("mid_rst_err", 64'(err), 64'd0);

        // Normal frame after the abort
        frame(0);
        run_stages();

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        $fatal(1, "bench timed out");
    end

endmodule
